// File: rtl/hamming_decoder.sv
// Streaming Hamming(7,4) SEC decoder: syndrome in stage 1, correction in stage 2,
// plus a saturating count of corrected words handed downstream.
module hamming_decoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [6:0]       in_code,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       out_data,
   output logic             out_err,
   output logic [2:0]       out_syndrome,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] corr_count
);

   logic             w_s1_adv;
   logic             w_s2_adv;
   logic             r_s1_valid;
   logic [3:0]       r_s1_data;
   logic [2:0]       r_s1_syn;
   logic             r_s2_valid;
   logic [3:0]       r_s2_data;
   logic             r_s2_err;
   logic [2:0]       r_s2_syn;
   logic [CNT_W-1:0] r_cnt;

   // Syndrome {s4, s2, s1}; codeword bit 7-k holds position k.
   function automatic logic [2:0] f_syndrome(input logic [6:0] c);
      logic s1, s2, s4;
      s1 = c[6] ^ c[4] ^ c[2] ^ c[0];
      s2 = c[5] ^ c[4] ^ c[1] ^ c[0];
      s4 = c[3] ^ c[2] ^ c[1] ^ c[0];
      return {s4, s2, s1};
   endfunction

   // Only data positions 3, 5, 6, 7 matter; a parity-position syndrome leaves data untouched.
   function automatic logic [3:0] f_correct(input logic [3:0] d, input logic [2:0] s);
      return {d[3] ^ (s == 3'd3), d[2] ^ (s == 3'd5), d[1] ^ (s == 3'd6), d[0] ^ (s == 3'd7)};
   endfunction

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   // Stage 1: capture data bits and syndrome
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (w_s1_adv && in_valid) begin
         r_s1_data <= {in_code[4], in_code[2], in_code[1], in_code[0]};
         r_s1_syn  <= f_syndrome(in_code);
      end
   end

   // Stage 2: correct and register outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_data  <= 4'd0;
         r_s2_err   <= 1'b0;
         r_s2_syn   <= 3'd0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_data <= f_correct(r_s1_data, r_s1_syn);
            r_s2_err  <= (r_s1_syn != 3'd0);
            r_s2_syn  <= r_s1_syn;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (cnt_clr) begin
         r_cnt <= '0;
      end else if (r_s2_valid && out_ready && r_s2_err) begin
         r_cnt <= f_sat_inc(r_cnt);
      end
   end

   assign out_valid    = r_s2_valid;
   assign out_data     = r_s2_data;
   assign out_err      = r_s2_err;
   assign out_syndrome = r_s2_syn;
   assign corr_count   = r_cnt;

endmodule

// File: doc/hamming_decoder.md
# hamming_decoder

Streaming Hamming(7,4) single-error-correcting decoder; receive-side counterpart of the team's 7-bit Hamming encoder. Accepts 7-bit codewords over a valid/ready handshake and computes the 3-bit syndrome. It corrects any single flipped bit and emits the 4-bit data word with error status through a 2-stage registered pipeline. A saturating counter tracks how many corrected words have been delivered.

## Interface
- CNT_W, 16, width of the corrected-word counter
- clk  input  1  rising-edge clock, sole clock domain
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_code holds a codeword
- in_ready  output  1  decoder accepts in_code this cycle
- in_code  input  7  codeword, bit order {p1, p2, d3, p4, d2, d1, d0} (bit 6 = p1, bit 0 = d0)
- out_valid  output  1  out_* fields hold a decoded word
- out_ready  input  1  downstream accepts this cycle
- out_data  output  4  corrected data {d3, d2, d1, d0}
- out_err  output  1  syndrome was nonzero (one bit corrected)
- out_syndrome  output  3  {s4, s2, s1}; equals the 1-based position of the flipped bit
- cnt_clr  input  1  synchronous clear of corr_count
- corr_count  output  CNT_W  delivered words with out_err=1, saturating

## Operation
- Codeword positions 1..7 map to in_code bits 6..0 (position k = bit 7-k).
- s1 = p1^d3^d2^d0.
- s2 = p2^d3^d1^d0.
- s4 = p4^d2^d1^d0.
- Stage 1 (S1) registers the codeword and syndrome on input handshake (in_valid && in_ready).
- Stage 2 (S2):
  - Inverts codeword bit (7 - syndrome) when syndrome != 0.
  - Registers data bits {6-2=4, 2, 1, 0} of the corrected word as out_data.
  - Registers out_err = (syndrome != 0) and out_syndrome.
- Syndrome 1, 2 or 4 (parity bit error): out_data equals the received data bits; out_err=1.
- SEC only: double errors are not detected. They yield a nonzero syndrome and a miscorrection, reported as out_err=1.
- Pipeline control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational).
  - S1 loads when s1_adv. Its valid bit becomes in_valid.
  - S2 loads from S1 when s2_adv. Its valid bit becomes s1_valid.
  - Registers hold while stalled.
- out_* are driven directly from S2 registers, with no combinational path from in_code.
- out_* stay stable while out_valid && !out_ready.
- corr_count:
  - Increments by 1 on output handshake with out_err=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr forces 0 and takes priority over a same-cycle increment.

## Timing
- Reset (async assert, release synchronous to clk):
  - s1_valid, out_valid = 0
  - out_data, out_syndrome, out_err = 0
  - corr_count = 0
  - in_ready = 1 in the first cycle after release
- Latency: codeword accepted at edge N gives out_valid=1 after edge N+1, with no stall.
- Throughput: 1 word/cycle with out_ready held high.
- Backpressure:
  - With out_ready=0, at most 2 words are held (S1 and S2).
  - in_ready drops once both stages are full.
  - in_ready rises in the same cycle out_ready returns high.
- Simultaneous output and input handshakes when full: both stages advance in one cycle; no bubble, no loss, no duplication.
- in_code is ignored when in_valid=0.
- in_valid may drop at any time without a handshake.
- Reset mid-stream: all in-flight words are discarded; no partial output.
- Saturation: at 2^CNT_W-1, further corrected words leave the count unchanged.
- cnt_clr during an erroneous handshake: result is 0.

## Test plan
- Clean word: in_code=7'h33 (data 4'b1011), out_ready=1 → two cycles later out_data=4'b1011, out_err=0, out_syndrome=0, corr_count=0.
- Data error: 7'h23 (d3 flipped) → out_data=4'b1011, out_err=1, out_syndrome=3, corr_count=1. Parity error: 7'h73 (p1 flipped) → out_data=4'b1011, out_syndrome=1.
- All 16 data values × 8 patterns (no flip, each of 7 single flips), streamed back-to-back at 1 word/cycle → every output equals the original data. out_syndrome equals the flipped position, or 0 when no bit was flipped. corr_count=112.
- Backpressure:
  - Stream 10 words with out_ready toggling randomly; in_valid gaps allowed.
  - Required: in-order delivery, no drop or duplication, out_* stable while stalled.
  - in_ready=0 exactly when both stages are full and out_ready=0.
- Double error: 7'h30 (d1, d0 flipped) → out_syndrome=1, out_data=4'b1000, out_err=1 (documented miscorrection).
- Counter and reset:
  - With CNT_W=2, deliver 5 corrected words → corr_count stays at 3.
  - cnt_clr asserted together with an erroneous handshake → corr_count=0.
  - rst asserted with both stages full → out_valid=0 and corr_count=0 immediately; no stale word after release.
